// File: rtl/mul_pkg.sv
// mul_pkg: shared width, sequencer state and Booth digit operation encodings for booth_mul_seq
package mul_pkg;
  localparam int MUL_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_op_t;
endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: start/m_in/q_in request from control (master) and busy/done/hi_out/lo_out result from the multiplier (slave)
interface booth_mul_seq_if import mul_pkg::*; #(parameter int WIDTH = MUL_WIDTH);
  logic start;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH-1:0] q_in;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master (output start, m_in, q_in, input busy, done, hi_out, lo_out);
  modport slave (input start, m_in, q_in, output busy, done, hi_out, lo_out);
endinterface

// File: rtl/booth_digit_enc.sv
// booth_digit_enc: recodes a {q[i+1],q[i],q[i-1]} group into a Booth op and its WIDTH+2-bit sign-extended partial product of m (ports grp, m in; pp out)
module booth_digit_enc import mul_pkg::*; #(parameter int WIDTH = MUL_WIDTH) (
  input  logic [2:0]       grp,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] pp
);
  booth_op_t op;
  logic [WIDTH+1:0] m1, m2;
  always_comb begin
    op = (grp == 3'b001 || grp == 3'b010) ? POS1 :
         (grp == 3'b011) ? POS2 :
         (grp == 3'b100) ? NEG2 :
         (grp == 3'b101 || grp == 3'b110) ? NEG1 : ZERO;
    m1 = {{2{m[WIDTH-1]}}, m};
    m2 = m1 << 1;
    pp = (op == POS1) ? m1 :
         (op == POS2) ? m2 :
         (op == NEG1) ? -m1 :
         (op == NEG2) ? -m2 : '0;
  end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth signed multiplier (ports clock, reset, bus: booth_mul_seq_if.slave); MUL_ZERO_BYPASS_EN skips RUN for a zero operand
module booth_mul_seq import mul_pkg::*; #(
  parameter int WIDTH = MUL_WIDTH,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input logic clock,
  input logic reset,
  booth_mul_seq_if.slave bus
);
  localparam int N = WIDTH / (2 * DIGITS_PER_CYCLE);
  localparam int PW = 2 * WIDTH + 3;
  localparam int CW = $clog2(N + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] m;
  logic [PW-1:0] p, p_nxt;
  logic [WIDTH+1:0] pp [DIGITS_PER_CYCLE];
  logic byp;
  for (genvar d = 0; d < DIGITS_PER_CYCLE; d++) begin : g_enc
    booth_digit_enc #(.WIDTH(WIDTH)) u_enc (.grp(p[2*d+2:2*d]), .m(m), .pp(pp[d]));
  end
`ifdef MUL_ZERO_BYPASS_EN
  assign byp = (bus.m_in == '0) || (bus.q_in == '0);
`else
  assign byp = 1'b0;
`endif
  // p = {acc[WIDTH+1:0], Q, q[-1]}; the encoders read the stage-d group straight from p because additions only touch the top bits
  always_comb begin
    p_nxt = p;
    for (int d = 0; d < DIGITS_PER_CYCLE; d++) begin
      p_nxt[PW-1:WIDTH+1] = p_nxt[PW-1:WIDTH+1] + pp[d];
      p_nxt = PW'($signed(p_nxt) >>> 2);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      m <= '0;
      p <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          m <= bus.m_in;
          p <= byp ? '0 : {{(WIDTH+2){1'b0}}, bus.q_in, 1'b0};
          cnt <= CW'(N);
          state <= byp ? DONE : RUN;
          bus.busy <= 1'b1;
        end
        RUN: begin
          p <= p_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bus.hi_out <= p[2*WIDTH:WIDTH+1];
          bus.lo_out <= p[WIDTH:1];
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: randomized self-checking bench for booth_mul_seq (1 and 4 digits per cycle) against a 64-bit integer product model
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  booth_mul_seq_if #(.WIDTH(32)) b ();
  booth_mul_seq_if #(.WIDTH(32)) b4 ();
  booth_mul_seq #(.WIDTH(32), .DIGITS_PER_CYCLE(1)) dut (.clock(clk), .reset(rst), .bus(b));
  booth_mul_seq #(.WIDTH(32), .DIGITS_PER_CYCLE(4)) dut4 (.clock(clk), .reset(rst), .bus(b4));
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] c);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(c));
    return 64'(x * y);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] c, output int lat);
    b.m_in = a;
    b.q_in = c;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    b.m_in = $urandom;
    b.q_in = $urandom;
    lat = 0;
    while (!b.done && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  task automatic op4(input logic [31:0] a, input logic [31:0] c, output int lat);
    b4.m_in = a;
    b4.q_in = c;
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    b4.m_in = $urandom;
    b4.q_in = $urandom;
    lat = 0;
    while (!b4.done && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 4;
    if (b.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", b.busy); end
    if (b.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", b.done); end
    if (b.hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h want=0", b.hi_out); end
    if (b.lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h want=0", b.lo_out); end
  endtask
  task automatic test_basic();
    int lat;
    b.m_in = 32'd7;
    b.q_in = 32'd6;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    checks++;
    if (b.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", b.busy); end
    lat = 0;
    while (!b.done && lat < 40) begin
      tick();
      lat++;
    end
    checks += 3;
    if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d want=17", lat); end
    if ({b.hi_out, b.lo_out} !== 64'd42) begin failures++; $display("FAIL basic_product got=%h%h want=%h", b.hi_out, b.lo_out, 64'd42); end
    if (b.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", b.busy); end
    tick();
    checks++;
    if (b.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", b.done); end
  endtask
  task automatic test_corners();
    logic [31:0] ta [7] = '{32'hFFFFFFFB, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tq [7] = '{32'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1234, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [63:0] want [7] = '{64'hFFFFFFFF_FFFFFFF1, 64'h00000000_80000000, 64'h40000000_00000000,
                              64'h3FFFFFFF_00000001, 64'h0, 64'hC0000000_80000000, 64'h1};
    int lat;
    for (int i = 0; i < 7; i++) begin
      tick();
      op(ta[i], tq[i], lat);
      checks += 2;
      if (lat !== 17) begin failures++; $display("FAIL corner%0d_latency got=%0d want=17", i, lat); end
      if ({b.hi_out, b.lo_out} !== want[i]) begin failures++; $display("FAIL corner%0d_product got=%h%h want=%h", i, b.hi_out, b.lo_out, want[i]); end
    end
  endtask
  task automatic test_random();
    logic [31:0] a, c;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      c = $urandom;
      if (i % 5 == 1) a = {1'b1, 31'($urandom_range(0, 3))};
      if (i % 5 == 2) c = 32'($urandom_range(0, 7)) - 32'd4;
      exp = ref_mul(a, c);
      tick();
      op(a, c, lat);
      checks += 2;
      if (lat !== 17) begin failures++; $display("FAIL rand%0d_latency got=%0d want=17", i, lat); end
      if ({b.hi_out, b.lo_out} !== exp) begin failures++; $display("FAIL rand%0d_product a=%h q=%h got=%h%h want=%h", i, a, c, b.hi_out, b.lo_out, exp); end
    end
  endtask
  task automatic test_ignore_start();
    logic [63:0] prev, exp;
    logic [31:0] a, c;
    int cyc;
    int extra;
    prev = {b.hi_out, b.lo_out};
    a = $urandom | 32'h1;
    c = $urandom | 32'h1;
    exp = ref_mul(a, c);
    tick();
    b.m_in = a;
    b.q_in = c;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    cyc = 0;
    while (!b.done && cyc < 40) begin
      b.start = (cyc == 3 || cyc == 9 || cyc == 16);
      b.m_in = $urandom;
      b.q_in = $urandom;
      tick();
      cyc++;
      if (!b.done) begin
        checks++;
        if ({b.hi_out, b.lo_out} !== prev) begin failures++; $display("FAIL ignore_hold cyc=%0d got=%h%h want=%h", cyc, b.hi_out, b.lo_out, prev); end
      end
    end
    b.start = 1'b0;
    checks += 2;
    if (cyc !== 17) begin failures++; $display("FAIL ignore_latency got=%0d want=17", cyc); end
    if ({b.hi_out, b.lo_out} !== exp) begin failures++; $display("FAIL ignore_product got=%h%h want=%h", b.hi_out, b.lo_out, exp); end
    extra = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (b.done || b.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL ignore_queued got=%0d want=0", extra); end
  endtask
  task automatic test_reset_mid();
    int dones;
    int lat;
    logic [31:0] a, c;
    tick();
    b.m_in = $urandom;
    b.q_in = $urandom;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (b.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", b.busy); end
    if (b.hi_out !== 32'h0) begin failures++; $display("FAIL midreset_hi got=%h want=0", b.hi_out); end
    if (b.lo_out !== 32'h0) begin failures++; $display("FAIL midreset_lo got=%h want=0", b.lo_out); end
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (b.done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL midreset_done got=%0d want=0", dones); end
    a = $urandom;
    c = $urandom;
    op(a, c, lat);
    checks += 2;
    if (lat !== 17) begin failures++; $display("FAIL midreset_fresh_latency got=%0d want=17", lat); end
    if ({b.hi_out, b.lo_out} !== ref_mul(a, c)) begin failures++; $display("FAIL midreset_fresh_product got=%h%h want=%h", b.hi_out, b.lo_out, ref_mul(a, c)); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] a, c;
    int lat;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      c = $urandom;
      op(a, c, lat);
      checks += 2;
      if (lat !== 17) begin failures++; $display("FAIL b2b%0d_latency got=%0d want=17", i, lat); end
      if ({b.hi_out, b.lo_out} !== ref_mul(a, c)) begin failures++; $display("FAIL b2b%0d_product got=%h%h want=%h", i, b.hi_out, b.lo_out, ref_mul(a, c)); end
    end
  endtask
  task automatic test_dpc4();
    logic [31:0] ta [4] = '{32'd7, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] tq [4] = '{32'd6, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] a, c;
    int lat;
    for (int i = 0; i < 10; i++) begin
      a = (i < 4) ? ta[i] : $urandom;
      c = (i < 4) ? tq[i] : $urandom;
      tick();
      op4(a, c, lat);
      checks += 2;
      if (lat !== 5) begin failures++; $display("FAIL dpc4_%0d_latency got=%0d want=5", i, lat); end
      if ({b4.hi_out, b4.lo_out} !== ref_mul(a, c)) begin failures++; $display("FAIL dpc4_%0d_product got=%h%h want=%h", i, b4.hi_out, b4.lo_out, ref_mul(a, c)); end
    end
  endtask
  initial begin
    b.start = 1'b0;
    b.m_in = '0;
    b.q_in = '0;
    b4.start = 1'b0;
    b4.m_in = '0;
    b4.q_in = '0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_dpc4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
